rr_arbiter_param: RTL and testbench

//   Parametrised N-way round-robin arbiter with a registered one-hot grant and a per-grant hold quantum.
//   A grantee keeps the grant while its request stays high, up to HOLD_MAX cycles when others wait.
//   It then yields to the next requester in rotation.

---
 rtl/rr_arbiter_param.sv | 149 ++++++++++++++
 tb/tb_rr_arbiter_param.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_param.sv
// Parametrised N-way round-robin arbiter: registered one-hot grant, per-grant hold quantum.
// Optional feature macro RR_ARB_LOCK_EN adds a lock input that lets the owner hold past its quantum.
module rr_arbiter_param #(
  parameter int  N        = 4,
  parameter int  HOLD_MAX = 4,
  localparam int IDW      = $clog2(N),
  localparam int CW       = $clog2(HOLD_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
`ifdef RR_ARB_LOCK_EN
  input  logic           lock,
`endif
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld
);

  localparam logic [CW-1:0]  HOLD_MAX_C = CW'(HOLD_MAX);
  localparam logic [IDW-1:0] LAST_ID    = IDW'(N - 1);

  typedef enum logic {IDLE, GRANT} state_e;
  typedef enum logic [1:0] {ACT_IDLE, ACT_NEW, ACT_KEEP} act_e;

  state_e         state_q, state_d;
  act_e           act;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           gnt_vld_q, gnt_vld_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]   other_req;
  logic           own_req;
  logic           win_vld;
  logic [IDW-1:0] win_id;
  logic           lock_hold;

`ifdef RR_ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  // Rotating search over everyone except the current owner, starting at ptr.
  // In IDLE gnt_q is zero, so the mask is a no-op there.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    idx       = 0;
    other_req = req & ~gnt_q;
    own_req   = |(req & gnt_q);
    win_vld   = 1'b0;
    win_id    = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!win_vld && other_req[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  // State register; grant, owner, pointer and hold counter update alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state: decide whether to idle, hand over, or keep the current owner.
  always_comb begin
    state_d = state_q;
    act     = ACT_KEEP;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          act     = ACT_NEW;
        end else begin
          act     = ACT_IDLE;
        end
      end
      GRANT: begin
        if (!own_req) begin
          if (win_vld) begin
            act     = ACT_NEW;
          end else begin
            state_d = IDLE;
            act     = ACT_IDLE;
          end
        end else if (cnt_q == HOLD_MAX_C && win_vld && !lock_hold) begin
          act = ACT_NEW;
        end else begin
          act = ACT_KEEP;
        end
      end
      default: begin
        state_d = IDLE;
        act     = ACT_IDLE;
      end
    endcase
  end

  // Output: next values of the registered grant, owner id, pointer and counter.
  always_comb begin
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    case (act)
      ACT_NEW: begin
        gnt_d         = '0;
        gnt_d[win_id] = 1'b1;
        gnt_id_d      = win_id;
        ptr_d         = (win_id == LAST_ID) ? '0 : win_id + IDW'(1);
        cnt_d         = CW'(1);
      end
      ACT_KEEP: begin
        if (cnt_q != HOLD_MAX_C) cnt_d = cnt_q + CW'(1);
      end
      default: begin
        gnt_d = '0;
        cnt_d = '0;
      end
    endcase
    gnt_vld_d = |gnt_d;
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Directed, table-driven bench for rr_arbiter_param (N=4, HOLD_MAX=4).
// Build with RR_ARB_LOCK_EN defined to also exercise the lock input.
module tb_rr_arbiter_param;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
`ifdef RR_ARB_LOCK_EN
  logic       lock;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter_param #(.N(4), .HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
`ifdef RR_ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] id);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
    check({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(|g));
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id, input int reps);
    for (int i = 0; i < reps; i++) vecs.push_back('{req: r, gnt: g, id: id});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req = 4'b0000;
`ifdef RR_ARB_LOCK_EN
    lock = 1'b0;
`endif

    // Held in reset with every requester active: nothing may be granted.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("reset[%0d]", i), 4'b0000, 2'd0);
    end
    rst = 1'b1;

    // Full contention: quantum of 4 per requester, wrapping back to 0.
    add(4'b1111, 4'b0001, 2'd0, 4);
    add(4'b1111, 4'b0010, 2'd1, 4);
    add(4'b1111, 4'b0100, 2'd2, 4);
    add(4'b1111, 4'b1000, 2'd3, 4);
    add(4'b1111, 4'b0001, 2'd0, 1);
    add(4'b0000, 4'b0000, 2'd0, 1);
    // Single one-cycle request; search from ptr=1 wraps to 0.
    add(4'b0001, 4'b0001, 2'd0, 1);
    add(4'b0000, 4'b0000, 2'd0, 1);
    // Lone requester keeps the grant well past the quantum.
    add(4'b0100, 4'b0100, 2'd2, 10);
    add(4'b0000, 4'b0000, 2'd2, 1);
    // Handover without a bubble, no preemption by a new request, then rotation wrap.
    add(4'b0010, 4'b0010, 2'd1, 1);
    add(4'b1000, 4'b1000, 2'd3, 1);
    add(4'b1001, 4'b1000, 2'd3, 3);
    add(4'b1001, 4'b0001, 2'd0, 1);
    add(4'b0001, 4'b0001, 2'd0, 1);
    add(4'b0000, 4'b0000, 2'd0, 1);

    foreach (vecs[i]) begin
      req = vecs[i].req;
      step();
      check_out($sformatf("vec[%0d]", i), vecs[i].gnt, vecs[i].id);
    end

    // Asynchronous reset pulse mid-grant, away from any clock edge.
    req = 4'b1111;
    step();
    check_out("pre_rst", 4'b0010, 2'd1);
    #3;
    rst = 1'b0;
    #1;
    check_out("async_rst", 4'b0000, 2'd0);
    step();
    check_out("rst_edge", 4'b0000, 2'd0);
    rst = 1'b1;
    step();
    check_out("post_rst", 4'b0001, 2'd0);

`ifdef RR_ARB_LOCK_EN
    // Lock keeps the owner past the quantum; releasing it rotates on the next edge.
    lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_out($sformatf("lock[%0d]", i), 4'b0001, 2'd0);
    end
    lock = 1'b0;
    step();
    check_out("unlock", 4'b0010, 2'd1);
`else
    // Without lock the same owner rotates out after its quantum.
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("quantum[%0d]", i), 4'b0001, 2'd0);
    end
    step();
    check_out("rotate", 4'b0010, 2'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
